// File: rtl/if_pkg.sv
// Shared fetch-stage defaults and the {pc, instr} entry layout used by the fetch queue.
package if_pkg;

    localparam int unsigned XLEN_DEFAULT     = 32;
    localparam int unsigned PC_STEP_DEFAULT  = 4;
    localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_ALIGN_BITS    = $clog2(PC_STEP_DEFAULT);

    // Queue entries are packed with pc in the upper half and instr in the lower half.
    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// IF/ID valid/ready handshake carrying the head instruction, its pc and its fall-through npc.
interface if_fetch_stage_if
    import if_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
);

    logic            if_id_valid;
    logic            id_ready;
    logic [XLEN-1:0] if_id_instr;
    logic [XLEN-1:0] if_id_pc;
    logic [XLEN-1:0] if_id_npc;

    modport master (
        output if_id_valid,
        output if_id_instr,
        output if_id_pc,
        output if_id_npc,
        input  id_ready
    );

    modport slave (
        input  if_id_valid,
        input  if_id_instr,
        input  if_id_pc,
        input  if_id_npc,
        output id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Power-of-two fetch queue with synchronous flush; flush beats push and pop in the same cycle.
module fetch_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 2 * XLEN_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [W-1:0]               head_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [W-1:0]    mem_q [DEPTH];
    logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + PtrW'(1);
            if (pop_i)  rd_d = rd_q + PtrW'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the top gates head fields with valid.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: registered PC, one-cycle-latency imem port, in-flight tracking, fetch queue
// to decode, and branch-redirect flush.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     PC_STEP  = PC_STEP_DEFAULT,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_mem_pcsrc,
    input  logic [XLEN-1:0]       ex_mem_npc,
    output logic                  imem_req,
    output logic [XLEN-1:0]       imem_addr,
    input  logic [XLEN-1:0]       imem_rdata,
    if_fetch_stage_if.master      if_id
);

    localparam int unsigned     CntW   = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] Step   = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] PcMask = ~(XLEN'(PC_STEP - 1));

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic [CntW-1:0]   count;
    logic [2*XLEN-1:0] head;
    logic [CntW:0]     occupancy;
    logic              valid, pop, push, issue;
    logic [XLEN-1:0]   head_pc, head_instr;

    assign valid = (count != '0);
    assign pop   = valid & if_id.id_ready;
    assign push  = inflight_q & ~ex_mem_pcsrc;

    // Slots already promised: queued entries minus this cycle's pop plus the response in flight.
    assign occupancy = {1'b0, count} - (CntW + 1)'(pop) + (CntW + 1)'(inflight_q);
    assign issue     = rst_n & ~ex_mem_pcsrc & (occupancy < (CntW + 1)'(DEPTH));

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (ex_mem_pcsrc) begin
            pc_d = ex_mem_npc & PcMask;
        end else if (issue) begin
            pc_d          = pc_q + Step;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (2 * XLEN)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (ex_mem_pcsrc),
        .push_i  (push),
        .wdata_i ({inflight_pc_q, imem_rdata}),
        .pop_i   (pop),
        .count_o (count),
        .head_o  (head)
    );

    assign head_pc    = head[2*XLEN-1:XLEN];
    assign head_instr = head[XLEN-1:0];

    assign imem_req  = issue;
    assign imem_addr = pc_q;

    assign if_id.if_id_valid = valid;
    assign if_id.if_id_pc    = valid ? head_pc : '0;
    assign if_id.if_id_instr = valid ? head_instr : '0;
    assign if_id.if_id_npc   = valid ? head_pc + Step : '0;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboarded bench for if_fetch_stage: DEPTH=2 instance for streaming/backpressure/redirect,
// DEPTH=4 instance for mid-stream reset.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_na, pcsrc_a, req_a;
    logic [31:0] npc_a, addr_a, rdata_a;
    logic        rst_nb, pcsrc_b, req_b;
    logic [31:0] npc_b, addr_b, rdata_b;

    if_fetch_stage_if #(.XLEN(32)) dif_a ();
    if_fetch_stage_if #(.XLEN(32)) dif_b ();

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .PC_STEP(4), .DEPTH(2)) dut_a (
        .clk          (clk),
        .rst_n        (rst_na),
        .ex_mem_pcsrc (pcsrc_a),
        .ex_mem_npc   (npc_a),
        .imem_req     (req_a),
        .imem_addr    (addr_a),
        .imem_rdata   (rdata_a),
        .if_id        (dif_a)
    );

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .PC_STEP(4), .DEPTH(4)) dut_b (
        .clk          (clk),
        .rst_n        (rst_nb),
        .ex_mem_pcsrc (pcsrc_b),
        .ex_mem_npc   (npc_b),
        .imem_req     (req_b),
        .imem_addr    (addr_b),
        .imem_rdata   (rdata_b),
        .if_id        (dif_b)
    );

    // Instruction memory: data word is the address divided by four, one cycle later.
    always @(posedge clk) begin
        rdata_a <= addr_a >> 2;
        rdata_b <= addr_b >> 2;
    end

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    // Compare any head decode takes this cycle against the scoreboard, then advance one cycle.
    task automatic end_cycle();
        logic [31:0] e, e_instr, e_npc;
        if (dif_a.if_id_valid && dif_a.id_ready && exp_q.size() > 0) begin
            e       = exp_q.pop_front();
            e_instr = e >> 2;
            e_npc   = e + 32'd4;
            n_assert++;
            if (dif_a.if_id_pc !== e || dif_a.if_id_instr !== e_instr
                || dif_a.if_id_npc !== e_npc) begin
                n_fail++;
                $display("FAIL sb_head: got pc=%h instr=%h npc=%h, expected pc=%h instr=%h npc=%h",
                         dif_a.if_id_pc, dif_a.if_id_instr, dif_a.if_id_npc, e, e_instr, e_npc);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: %0d heads still expected, required 0", name, exp_q.size());
        end
    endtask

    task automatic reset_a();
        rst_na = 1'b0;
        pcsrc_a = 1'b0;
        npc_a = '0;
        dif_a.id_ready = 1'b1;
        exp_q.delete();
        end_cycle();
        end_cycle();
        rst_na = 1'b1;
    endtask

    task automatic test_reset();
        rst_na = 1'b0;
        pcsrc_a = 1'b0;
        dif_a.id_ready = 1'b1;
        end_cycle();
        @(negedge clk);
        n_assert++;
        if ({req_a, addr_a, dif_a.if_id_valid} !== {1'b0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_req_addr_valid: got %b/%h/%b, expected 0/00000000/0",
                     req_a, addr_a, dif_a.if_id_valid);
        end
        n_assert++;
        if ({dif_a.if_id_instr, dif_a.if_id_pc, dif_a.if_id_npc} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_head: got instr=%h pc=%h npc=%h, expected all zero",
                     dif_a.if_id_instr, dif_a.if_id_pc, dif_a.if_id_npc);
        end
        end_cycle();
        rst_na = 1'b1;
    endtask

    task automatic test_stream();
        reset_a();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        @(negedge clk);
        n_assert++;
        if ({req_a, addr_a, dif_a.if_id_valid} !== {1'b1, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL stream_c1: got req=%b addr=%h valid=%b, expected 1/00000000/0",
                     req_a, addr_a, dif_a.if_id_valid);
        end
        end_cycle();
        @(negedge clk);
        n_assert++;
        if ({req_a, addr_a, dif_a.if_id_valid} !== {1'b1, 32'h4, 1'b0}) begin
            n_fail++;
            $display("FAIL stream_c2: got req=%b addr=%h valid=%b, expected 1/00000004/0",
                     req_a, addr_a, dif_a.if_id_valid);
        end
        end_cycle();
        for (int c = 3; c < 11; c++) begin
            @(negedge clk);
            n_assert++;
            if (dif_a.if_id_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_valid_c%0d: got %b, expected 1", c, dif_a.if_id_valid);
            end
            end_cycle();
        end
        check_drained("stream");
    endtask

    task automatic test_backpressure();
        reset_a();
        for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
        end_cycle();
        end_cycle();
        dif_a.id_ready = 1'b0;
        for (int c = 3; c < 8; c++) begin
            @(negedge clk);
            n_assert++;
            if ({req_a, dif_a.if_id_valid, dif_a.if_id_pc} !== {1'b0, 1'b1, 32'h0}) begin
                n_fail++;
                $display("FAIL stall_c%0d: got req=%b valid=%b pc=%h, expected 0/1/00000000",
                         c, req_a, dif_a.if_id_valid, dif_a.if_id_pc);
            end
            end_cycle();
        end
        dif_a.id_ready = 1'b1;
        repeat (10) end_cycle();
        check_drained("stall_release");
    endtask

    task automatic test_redirect_inflight();
        reset_a();
        dif_a.id_ready = 1'b0;
        end_cycle();
        end_cycle();
        pcsrc_a = 1'b1;
        npc_a = 32'h100;
        @(negedge clk);
        n_assert++;
        if ({req_a, dif_a.if_id_valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL redir_T: got req=%b valid=%b, expected 0/1", req_a, dif_a.if_id_valid);
        end
        end_cycle();
        pcsrc_a = 1'b0;
        dif_a.id_ready = 1'b1;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        @(negedge clk);
        n_assert++;
        if ({req_a, addr_a, dif_a.if_id_valid} !== {1'b1, 32'h100, 1'b0}) begin
            n_fail++;
            $display("FAIL redir_T1: got req=%b addr=%h valid=%b, expected 1/00000100/0",
                     req_a, addr_a, dif_a.if_id_valid);
        end
        end_cycle();
        @(negedge clk);
        n_assert++;
        if (dif_a.if_id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_T2_valid: got %b, expected 0", dif_a.if_id_valid);
        end
        end_cycle();
        @(negedge clk);
        n_assert++;
        if ({dif_a.if_id_valid, dif_a.if_id_pc} !== {1'b1, 32'h100}) begin
            n_fail++;
            $display("FAIL redir_T3_head: got valid=%b pc=%h, expected 1/00000100",
                     dif_a.if_id_valid, dif_a.if_id_pc);
        end
        repeat (5) end_cycle();
        check_drained("redir");
    endtask

    task automatic test_redirect_pop();
        reset_a();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        repeat (3) end_cycle();
        pcsrc_a = 1'b1;
        npc_a = 32'h203;
        @(negedge clk);
        n_assert++;
        if ({req_a, dif_a.if_id_valid, dif_a.if_id_pc} !== {1'b0, 1'b1, 32'h4}) begin
            n_fail++;
            $display("FAIL redirpop_T: got req=%b valid=%b pc=%h, expected 0/1/00000004",
                     req_a, dif_a.if_id_valid, dif_a.if_id_pc);
        end
        end_cycle();
        pcsrc_a = 1'b0;
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        exp_q.push_back(32'h208);
        @(negedge clk);
        n_assert++;
        if ({req_a, addr_a} !== {1'b1, 32'h200}) begin
            n_fail++;
            $display("FAIL redirpop_align: got req=%b addr=%h, expected 1/00000200", req_a, addr_a);
        end
        repeat (6) end_cycle();
        check_drained("redirpop");
    endtask

    task automatic test_wrap();
        reset_a();
        pcsrc_a = 1'b1;
        npc_a = 32'hFFFF_FFFC;
        @(negedge clk);
        n_assert++;
        if (req_a !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_T_req: got %b, expected 0", req_a);
        end
        end_cycle();
        pcsrc_a = 1'b0;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        @(negedge clk);
        n_assert++;
        if ({req_a, addr_a} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_fail++;
            $display("FAIL wrap_T1: got req=%b addr=%h, expected 1/fffffffc", req_a, addr_a);
        end
        end_cycle();
        @(negedge clk);
        n_assert++;
        if ({req_a, addr_a} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL wrap_T2: got req=%b addr=%h, expected 1/00000000", req_a, addr_a);
        end
        repeat (5) end_cycle();
        check_drained("wrap");
    endtask

    task automatic test_reset_mid();
        dif_a.id_ready = 1'b0;
        dif_b.id_ready = 1'b0;
        rst_nb = 1'b0;
        end_cycle();
        end_cycle();
        rst_nb = 1'b1;
        repeat (8) end_cycle();
        @(negedge clk);
        n_assert++;
        if ({req_b, dif_b.if_id_valid, dif_b.if_id_pc} !== {1'b0, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL rstmid_full: got req=%b valid=%b pc=%h, expected 0/1/00000000",
                     req_b, dif_b.if_id_valid, dif_b.if_id_pc);
        end
        end_cycle();
        rst_nb = 1'b0;
        end_cycle();
        @(negedge clk);
        n_assert++;
        if ({req_b, dif_b.if_id_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_after: got req=%b valid=%b, expected 0/0",
                     req_b, dif_b.if_id_valid);
        end
        end_cycle();
        rst_nb = 1'b1;
        dif_b.id_ready = 1'b1;
        @(negedge clk);
        n_assert++;
        if ({req_b, addr_b} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL rstmid_restart: got req=%b addr=%h, expected 1/00000000", req_b, addr_b);
        end
        end_cycle();
        end_cycle();
        @(negedge clk);
        n_assert++;
        if ({dif_b.if_id_valid, dif_b.if_id_pc, dif_b.if_id_instr, dif_b.if_id_npc}
            !== {1'b1, 32'h0, 32'h0, 32'h4}) begin
            n_fail++;
            $display("FAIL rstmid_head: got valid=%b pc=%h instr=%h npc=%h, expected 1/0/0/4",
                     dif_b.if_id_valid, dif_b.if_id_pc, dif_b.if_id_instr, dif_b.if_id_npc);
        end
        end_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_na = 1'b0;
        rst_nb = 1'b0;
        pcsrc_a = 1'b0;
        pcsrc_b = 1'b0;
        npc_a = '0;
        npc_b = '0;
        dif_a.id_ready = 1'b0;
        dif_b.id_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_pop();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
